pipeline_stall_regs: RTL and testbench

//  Consumer end of the load-use stall interface: PC register, IF/ID register and ID/EX register of the 5-stage RV64 pipeline.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_reg.sv | 25 ++
 rtl/pipeline_stall_regs.sv | 124 ++++++++++++
 tb/tb_pipeline_stall_regs.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the RV64 pipeline register slice.
//   XLEN       datapath / PC width
//   NOP_INSTR  addi x0,x0,0, loaded into IF/ID on reset and flush
//   RESET_PC   default PC after reset
//   CTRL_W     width of the decoded control bundle carried into EX
//   CTRL_*     bit positions inside the control bundle
package pipe_pkg;

  localparam int              XLEN      = 64;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = '0;
  localparam int              CTRL_W    = 8;

  // Control bundle layout: {branch,RegWrite,MemtoReg,MemRead,MemWrite,alu_src,alu_op[1:0]}
  localparam int CTRL_BRANCH    = 7;
  localparam int CTRL_REG_WRITE = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_MEM_READ  = 4;
  localparam int CTRL_MEM_WRITE = 3;
  localparam int CTRL_ALU_SRC   = 2;
  localparam int CTRL_ALU_OP_HI = 1;
  localparam int CTRL_ALU_OP_LO = 0;

endpackage

// File: rtl/pipe_reg.sv
// Generic W-bit pipeline register with synchronous clear and load enable.
//   clk  rising-edge clock
//   en   1 = load d
//   clr  1 = load CLR_VAL; takes priority over en
//   d    next value
//   q    registered value
module pipe_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and stage ordering cannot create races.
  always_ff @(posedge clk) begin
    if (clr)     q <= CLR_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipeline_stall_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage RV64 pipeline, driven by the
// load-use hazard unit (stall, IF_ID_Write, PC_Write) and EX branch resolution.
// A taken branch redirects the PC and flushes IF/ID and ID/EX; a stall freezes
// PC and IF/ID and drops a zero-control bubble into ID/EX.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   stall, IF_ID_Write, PC_Write  hazard-unit controls
//   branch_taken, branch_target   redirect request from EX
//   instr_in                   fetched instruction for the current pc
//   id_ctrl, id_rs1/rs2/rd, id_rs1_data/rs2_data/imm  decoded ID fields
//   pc                         fetch address
//   IF_ID_pc/instr/valid       IF/ID register contents
//   ID_EX_*                    ID/EX register contents
// Optional build macro PIPE_PERF_CNT_EN adds saturating stall_count and
// flush_count outputs.
module pipeline_stall_regs
  import pipe_pkg::*;
#(
  parameter int              XLEN      = pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = pipe_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              IF_ID_Write,
  input  logic              PC_Write,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic [31:0]       instr_in,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   IF_ID_pc,
  output logic [31:0]       IF_ID_instr,
  output logic              IF_ID_valid,
  output logic [CTRL_W-1:0] ID_EX_ctrl,
  output logic [4:0]        ID_EX_rs1,
  output logic [4:0]        ID_EX_rs2,
  output logic [4:0]        ID_EX_rd,
  output logic [XLEN-1:0]   ID_EX_rs1_data,
  output logic [XLEN-1:0]   ID_EX_rs2_data,
  output logic [XLEN-1:0]   ID_EX_imm,
  output logic [XLEN-1:0]   ID_EX_pc,
  output logic              ID_EX_valid
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count
`endif
);

  localparam int IF_ID_W = XLEN + 32 + 1;
  localparam int ID_EX_W = CTRL_W + 15 + 4 * XLEN + 1;
  localparam logic [IF_ID_W-1:0] IF_ID_CLR = {{XLEN{1'b0}}, NOP_INSTR, 1'b0};

  // ---------------- PC ----------------
  // Redirect targets are forced word-aligned; sequential fetch wraps mod 2^XLEN.
  logic [XLEN-1:0] pc_next;
  assign pc_next = branch_taken ? {branch_target[XLEN-1:2], 2'b00}
                                : pc + XLEN'(4);

  pipe_reg #(.W(XLEN), .CLR_VAL(RESET_PC)) u_pc (
    .clk (clk),
    .en  (branch_taken | PC_Write),
    .clr (rst),
    .d   (pc_next),
    .q   (pc)
  );

  // ---------------- IF/ID ----------------
  logic [IF_ID_W-1:0] if_id_d, if_id_q;
  assign if_id_d = {pc, instr_in, 1'b1};

  pipe_reg #(.W(IF_ID_W), .CLR_VAL(IF_ID_CLR)) u_if_id (
    .clk (clk),
    .en  (IF_ID_Write),
    .clr (rst | branch_taken),
    .d   (if_id_d),
    .q   (if_id_q)
  );

  assign {IF_ID_pc, IF_ID_instr, IF_ID_valid} = if_id_q;

  // ---------------- ID/EX ----------------
  // An invalid IF/ID slot still travels down but must never assert control.
  logic [CTRL_W-1:0]  ctrl_gated;
  logic [ID_EX_W-1:0] id_ex_d, id_ex_q;

  assign ctrl_gated = IF_ID_valid ? id_ctrl : '0;
  assign id_ex_d    = {ctrl_gated, id_rs1, id_rs2, id_rd,
                       id_rs1_data, id_rs2_data, id_imm, IF_ID_pc, IF_ID_valid};

  // Clearing the whole register is the bubble: zero control, rd=0, valid=0.
  pipe_reg #(.W(ID_EX_W), .CLR_VAL('0)) u_id_ex (
    .clk (clk),
    .en  (1'b1),
    .clr (rst | branch_taken | stall),
    .d   (id_ex_d),
    .q   (id_ex_q)
  );

  assign {ID_EX_ctrl, ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
          ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_pc, ID_EX_valid} = id_ex_q;

`ifdef PIPE_PERF_CNT_EN
  // ---------------- performance counters (saturating) ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1))        stall_count <= stall_count + 32'd1;
      if (branch_taken && (flush_count != '1)) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_regs.sv
// Directed bench for pipeline_stall_regs. Each step drives one cycle of
// inputs and queues the hand-computed register contents expected after that
// edge; an independent monitor pops and compares one entry per clock.
module tb_pipeline_stall_regs;

  localparam int          XLEN  = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [7:0]  CTRL  = 8'hC3;
  localparam logic [63:0] RS1_D = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RS2_D = 64'h5555_6666_7777_8888;
  localparam logic [63:0] IMM   = 64'h0000_0000_0000_0ABC;
  localparam logic [63:0] TOP   = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] if_pc;
    logic        if_v;
    logic [7:0]  ex_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_v;
    logic [63:0] ex_pc;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            stall = 1'b0, IF_ID_Write = 1'b0, PC_Write = 1'b0, branch_taken = 1'b0;
  logic [XLEN-1:0] branch_target = '0;
  logic [31:0]     instr_in;
  logic [7:0]      id_ctrl = CTRL;
  logic [4:0]      id_rs1 = 5'd1, id_rs2 = 5'd2, id_rd = 5'd7;
  logic [XLEN-1:0] id_rs1_data = RS1_D, id_rs2_data = RS2_D, id_imm = IMM;

  logic [XLEN-1:0] pc, IF_ID_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_pc;
  logic [31:0]     IF_ID_instr;
  logic            IF_ID_valid, ID_EX_valid;
  logic [7:0]      ID_EX_ctrl;
  logic [4:0]      ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]     stall_count, flush_count;
`endif

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t exp_q[$];

  // Instruction memory stand-in: the word encodes its own fetch address.
  assign instr_in = 32'hA000_0000 | pc[31:0];

  always #5 clk = ~clk;

  pipeline_stall_regs dut (
    .clk(clk), .rst(rst), .stall(stall), .IF_ID_Write(IF_ID_Write), .PC_Write(PC_Write),
    .branch_taken(branch_taken), .branch_target(branch_target), .instr_in(instr_in),
    .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .pc(pc), .IF_ID_pc(IF_ID_pc), .IF_ID_instr(IF_ID_instr), .IF_ID_valid(IF_ID_valid),
    .ID_EX_ctrl(ID_EX_ctrl), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data), .ID_EX_imm(ID_EX_imm),
    .ID_EX_pc(ID_EX_pc), .ID_EX_valid(ID_EX_valid)
`ifdef PIPE_PERF_CNT_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue what the registers must hold after the edge.
  task automatic step(input logic r, input logic st, input logic ifw, input logic pcw,
                      input logic br, input logic [63:0] tgt,
                      input logic [63:0] e_pc, input logic [63:0] e_if_pc, input logic e_if_v,
                      input logic [7:0] e_ctrl, input logic [4:0] e_rd, input logic e_ex_v,
                      input logic [63:0] e_ex_pc, input logic [31:0] e_sc, input logic [31:0] e_fc);
    exp_t e;
    @(negedge clk);
    rst = r; stall = st; IF_ID_Write = ifw; PC_Write = pcw;
    branch_taken = br; branch_target = tgt;
    @(posedge clk);
    e.pc = e_pc; e.if_pc = e_if_pc; e.if_v = e_if_v; e.ex_ctrl = e_ctrl;
    e.ex_rd = e_rd; e.ex_v = e_ex_v; e.ex_pc = e_ex_pc; e.sc = e_sc; e.fc = e_fc;
    exp_q.push_back(e);
  endtask

  // Monitor: compares one queued expectation per edge, 1 ns after the edge.
  always @(posedge clk) begin
    exp_t e;
    logic [31:0] e_instr;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      e_instr = e.if_v ? (32'hA000_0000 | e.if_pc[31:0]) : NOP;
      check("pc",          pc,          e.pc);
      check("IF_ID_valid", 64'(IF_ID_valid), 64'(e.if_v));
      check("IF_ID_instr", 64'(IF_ID_instr), 64'(e_instr));
      if (e.if_v) check("IF_ID_pc", IF_ID_pc, e.if_pc);
      check("ID_EX_ctrl",  64'(ID_EX_ctrl),  64'(e.ex_ctrl));
      check("ID_EX_rd",    64'(ID_EX_rd),    64'(e.ex_rd));
      check("ID_EX_valid", 64'(ID_EX_valid), 64'(e.ex_v));
      // rd=0 in these vectors means a cleared (bubble/reset) ID/EX slot.
      check("ID_EX_imm",      ID_EX_imm,      (e.ex_rd == 5'd0) ? 64'd0 : IMM);
      check("ID_EX_rs1_data", ID_EX_rs1_data, (e.ex_rd == 5'd0) ? 64'd0 : RS1_D);
      if (e.ex_v) check("ID_EX_pc", ID_EX_pc, e.ex_pc);
`ifdef PIPE_PERF_CNT_EN
      check("stall_count", 64'(stall_count), 64'(e.sc));
      check("flush_count", 64'(flush_count), 64'(e.fc));
`endif
    end
  end

  // Hazard-unit protocol: a stall must come with both write enables low.
  always @(posedge clk) begin
    if (!rst && stall && (IF_ID_Write || PC_Write)) begin
      n_fails++;
      $display("FAIL protocol: stall=1 with IF_ID_Write=%0b PC_Write=%0b", IF_ID_Write, PC_Write);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //   rst st ifw pcw br target      pc    if_pc v  ctrl rd v  ex_pc  sc fc
    // reset held two cycles
    step(1, 0, 0, 0, 0, 64'h0,   64'h0,   64'h0,   0, 8'h00, 5'd0, 0, 64'h0,   0, 0);
    step(1, 0, 0, 0, 0, 64'h0,   64'h0,   64'h0,   0, 8'h00, 5'd0, 0, 64'h0,   0, 0);
    // free run: pc 4,8,C,10; IF/ID lags by one, ID/EX by two
    step(0, 0, 1, 1, 0, 64'h0,   64'h4,   64'h0,   1, 8'h00, 5'd7, 0, 64'h0,   0, 0);
    step(0, 0, 1, 1, 0, 64'h0,   64'h8,   64'h4,   1, CTRL,  5'd7, 1, 64'h0,   0, 0);
    step(0, 0, 1, 1, 0, 64'h0,   64'hC,   64'h8,   1, CTRL,  5'd7, 1, 64'h4,   0, 0);
    step(0, 0, 1, 1, 0, 64'h0,   64'h10,  64'hC,   1, CTRL,  5'd7, 1, 64'h8,   0, 0);
    // reset from a running pipeline, then advance to pc=8
    step(1, 0, 1, 1, 0, 64'h0,   64'h0,   64'h0,   0, 8'h00, 5'd0, 0, 64'h0,   0, 0);
    step(0, 0, 1, 1, 0, 64'h0,   64'h4,   64'h0,   1, 8'h00, 5'd7, 0, 64'h0,   0, 0);
    step(0, 0, 1, 1, 0, 64'h0,   64'h8,   64'h4,   1, CTRL,  5'd7, 1, 64'h0,   0, 0);
    // single load-use stall at pc=8, then resume
    step(0, 1, 0, 0, 0, 64'h0,   64'h8,   64'h4,   1, 8'h00, 5'd0, 0, 64'h0,   1, 0);
    step(0, 0, 1, 1, 0, 64'h0,   64'hC,   64'h8,   1, CTRL,  5'd7, 1, 64'h4,   1, 0);
    // back-to-back stalls: one bubble each
    step(0, 1, 0, 0, 0, 64'h0,   64'hC,   64'h8,   1, 8'h00, 5'd0, 0, 64'h0,   2, 0);
    step(0, 1, 0, 0, 0, 64'h0,   64'hC,   64'h8,   1, 8'h00, 5'd0, 0, 64'h0,   3, 0);
    step(0, 0, 1, 1, 0, 64'h0,   64'h10,  64'hC,   1, CTRL,  5'd7, 1, 64'h8,   3, 0);
    // flush beats stall; target 0x103 aligns to 0x100
    step(0, 1, 0, 0, 1, 64'h103, 64'h100, 64'h0,   0, 8'h00, 5'd0, 0, 64'h0,   4, 1);
    step(0, 0, 1, 1, 0, 64'h0,   64'h104, 64'h100, 1, 8'h00, 5'd7, 0, 64'h0,   4, 1);
    step(0, 0, 1, 1, 0, 64'h0,   64'h108, 64'h104, 1, CTRL,  5'd7, 1, 64'h100, 4, 1);
    // branch to the top word, then sequential fetch wraps to 0
    step(0, 0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, TOP, 64'h0, 0, 8'h00, 5'd0, 0, 64'h0, 4, 2);
    step(0, 0, 1, 1, 0, 64'h0,   64'h0,   TOP,     1, 8'h00, 5'd7, 0, 64'h0,   4, 2);
    step(0, 0, 1, 1, 0, 64'h0,   64'h4,   64'h0,   1, CTRL,  5'd7, 1, TOP,     4, 2);
    // both enables low without stall: PC and IF/ID hold, ID/EX still captures
    step(0, 0, 0, 0, 0, 64'h0,   64'h4,   64'h0,   1, CTRL,  5'd7, 1, 64'h0,   4, 2);
    // reset during a stall+flush discards everything; fetch restarts at 0
    step(1, 1, 0, 0, 1, 64'h200, 64'h0,   64'h0,   0, 8'h00, 5'd0, 0, 64'h0,   0, 0);
    step(0, 0, 1, 1, 0, 64'h0,   64'h4,   64'h0,   1, 8'h00, 5'd7, 0, 64'h0,   0, 0);

    @(negedge clk);
    rst = 1'b0; stall = 1'b0; IF_ID_Write = 1'b0; PC_Write = 1'b0; branch_taken = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
